instr_sequencer: RTL

Instruction fetch/sequencing engine for the simple CPU. It fetches 16-bit instruction words from instruction memory over a valid-based read handshake and holds them in an instruction register. It walks the IDLE/FETCH/DECODE/EXECUTE/HALT cycle, drives the `state` and `opcode` buses consumed by the control unit, and applies the control unit's `pc_jump` decision to the program counter.

---
 rtl/instr_sequencer.sv | 94 +++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - instruction fetch/sequencing engine (IDLE/FETCH/DECODE/EXECUTE/HALT)
// Optional single-step gating of IDLE->FETCH via macro INSTR_SEQ_SINGLE_STEP_EN.
module instr_sequencer #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
`ifdef INSTR_SEQ_SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  input  logic            imem_valid,
  input  logic            pc_jump,
  output logic [2:0]      state,
  output logic [3:0]      opcode,
  output logic [1:0]      rd,
  output logic [1:0]      rs,
  output logic [7:0]      imm,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic [15:0]     retired
);

  localparam logic [2:0] ST_IDLE    = 3'b000;
  localparam logic [2:0] ST_FETCH   = 3'b001;
  localparam logic [2:0] ST_DECODE  = 3'b010;
  localparam logic [2:0] ST_EXECUTE = 3'b011;
  localparam logic [2:0] ST_HALT    = 3'b101;

  localparam logic [3:0] OP_HALT = 4'hF;

  logic [15:0] ir;
  logic        start_ok;
  logic        exec_continue;

`ifdef INSTR_SEQ_SINGLE_STEP_EN
  // One instruction per step: every EXECUTE parks in IDLE until the next step.
  assign start_ok      = run & step;
  assign exec_continue = 1'b0;
`else
  assign start_ok      = run;
  assign exec_continue = run;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      pc      <= '0;
      ir      <= '0;
      retired <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ok) state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (imem_valid) begin
            ir    <= imem_rdata;
            pc    <= pc + PC_W'(1);
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          state <= (ir[15:12] == OP_HALT) ? ST_HALT : ST_EXECUTE;
        end
        ST_EXECUTE: begin
          // A taken jump replaces the post-fetch increment.
          if (pc_jump) pc <= ir[PC_W-1:0];
          retired <= retired + 16'd1;
          state   <= exec_continue ? ST_FETCH : ST_IDLE;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_req  = (state == ST_FETCH);
  assign imem_addr = imem_req ? pc : '0;
  assign halted    = (state == ST_HALT);

  assign opcode = ir[15:12];
  assign rd     = ir[11:10];
  assign rs     = ir[9:8];
  assign imm    = ir[7:0];

endmodule
